megarom_spi_master: RTL and testbench

MEGAROM_SPI_MASTER -- requirements
Module: megarom_spi_master

---
 rtl/megarom_spi_master_pkg.sv | 57 +++++
 rtl/megarom_spi_master_phase_timer.sv | 31 +++
 rtl/megarom_spi_master.sv | 140 ++++++++++++++
 tb/tb_megarom_spi_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/megarom_spi_master_pkg.sv
// Shared definitions for the MegaROM SPI link between this master and the
// CPLD-side receiver: op encodings, fixed lock/unlock frames, 32-bit frame
// field positions, the master FSM state type and a frame builder.
package megarom_spi_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_LOCK   = 2'b10,   // disable BBC access
    OP_UNLOCK = 2'b11    // enable BBC access
  } op_e;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned ADDR_W     = 19;

  // Frame field positions
  localparam int unsigned ADDR_MSB   = 31;
  localparam int unsigned ADDR_LSB   = 13;
  localparam int unsigned RNW_BIT    = 12;
  localparam int unsigned WDATA_MSB  = 11;
  localparam int unsigned WDATA_LSB  = 4;

  localparam logic [31:0] FRAME_LOCK   = 32'hFFFF_FF00;
  localparam logic [31:0] FRAME_UNLOCK = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic logic [31:0] build_frame(input op_e        op,
                                              input logic [18:0] addr,
                                              input logic [7:0]  wdata);
    logic [31:0] f;
    f = '0;
    unique case (op)
      OP_WRITE: begin
        f[ADDR_MSB:ADDR_LSB]   = addr;
        f[RNW_BIT]             = 1'b0;
        f[WDATA_MSB:WDATA_LSB] = wdata;
      end
      OP_READ: begin
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[RNW_BIT]           = 1'b1;
      end
      OP_LOCK:   f = FRAME_LOCK;
      OP_UNLOCK: f = FRAME_UNLOCK;
      default:   f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/megarom_spi_master_phase_timer.sv
// spi_phase_timer: counts DIV clk cycles per SPI phase and raises a
// one-cycle phase_end strobe in the last cycle of each phase.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   clear     - hold the count at zero (no strobe while asserted)
//   phase_end - high in the final cycle of every DIV-cycle phase
module spi_phase_timer #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic phase_end
);

  logic [7:0] cnt;

  assign phase_end = !clear && (cnt == 8'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/megarom_spi_master.sv
// megarom_spi_master: issues one 32-bit SPI mode-0 frame per accepted
// command to the CPLD (write, read, lock, unlock) and reports completion.
// Ports:
//   clk, nRST                      - clock, async active-low reset
//   cmd_valid/cmd_ready            - command handshake (ready only in IDLE)
//   cmd_op, cmd_addr, cmd_wdata    - command fields, latched on accept
//   rsp_valid                      - one-cycle pulse when a frame completes
//   rsp_rdata                      - last 8 bits received, held until next frame
//   cpld_SS, cpld_SCK, cpld_MOSI   - SPI outputs to CPLD
//   cpld_MISO                      - SPI input from CPLD
module megarom_spi_master
  import megarom_spi_master_pkg::*;
#(
  parameter int unsigned SCK_DIV = 1,
  parameter int unsigned SS_GAP  = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cpld_SS,
  output logic        cpld_SCK,
  output logic        cpld_MOSI,
  input  logic        cpld_MISO
);

  spi_state_e  state;
  logic [30:0] tx_rest;   // frame bits still to send; cpld_MOSI holds the current bit
  logic [31:0] rx_sr;
  logic [5:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic [31:0] new_frame;
  logic        phase_end;
  logic        timer_clear;
  logic        unused_rx_top;

  assign new_frame     = build_frame(op_e'(cmd_op), cmd_addr, cmd_wdata);
  assign timer_clear   = (state == ST_IDLE) || (state == ST_GAP);
  // Only the low byte is reported; the oldest received bit falls off the end.
  assign unused_rx_top = rx_sr[31];

  spi_phase_timer #(
    .DIV (SCK_DIV)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (nRST),
    .clear     (timer_clear),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cpld_SS   <= 1'b1;
      cpld_SCK  <= 1'b0;
      cpld_MOSI <= 1'b0;
      tx_rest   <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cpld_SS   <= 1'b0;
            cpld_MOSI <= new_frame[31];
            tx_rest   <= new_frame[30:0];
            rx_sr     <= '0;
            bit_cnt   <= 6'd32;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_end) begin
            state <= ST_SCK_LO;
          end
        end

        ST_SCK_LO: begin
          if (phase_end) begin
            cpld_SCK <= 1'b1;
            state    <= ST_SCK_HI;
          end
        end

        ST_SCK_HI: begin
          // MISO is sampled in the last high cycle; the next MOSI bit
          // appears together with the falling SCK edge.
          if (phase_end) begin
            cpld_SCK <= 1'b0;
            rx_sr    <= {rx_sr[30:0], cpld_MISO};
            bit_cnt  <= bit_cnt - 6'd1;
            if (bit_cnt == 6'd1) begin
              state <= ST_HOLD;
            end else begin
              cpld_MOSI <= tx_rest[30];
              tx_rest   <= {tx_rest[29:0], 1'b0};
              state     <= ST_SCK_LO;
            end
          end
        end

        ST_HOLD: begin
          if (phase_end) begin
            cpld_SS   <= 1'b1;
            cpld_MOSI <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_sr[7:0];
            gap_cnt   <= 8'(SS_GAP - 1);
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_megarom_spi_master.sv
// Scoreboard bench for megarom_spi_master: stimulus pushes expected frames
// and read data; a monitor pops and compares on every rsp_valid.
module tb_megarom_spi_master;

  localparam int unsigned SS_GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [18:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cpld_SS, cpld_SCK, cpld_MOSI;
  logic        cpld_MISO = 1'b0;

  logic        c3_valid, c3_ready;
  logic [1:0]  c3_op;
  logic [18:0] c3_addr;
  logic [7:0]  c3_wdata;
  logic        c3_rsp;
  logic [7:0]  c3_rdata;
  logic        c3_ss, c3_sck, c3_mosi;
  logic        c3_miso = 1'b0;

  megarom_spi_master #(.SCK_DIV(1), .SS_GAP(SS_GAP)) dut (
    .clk(clk), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cpld_SS(cpld_SS), .cpld_SCK(cpld_SCK), .cpld_MOSI(cpld_MOSI), .cpld_MISO(cpld_MISO)
  );

  megarom_spi_master #(.SCK_DIV(3), .SS_GAP(SS_GAP)) dut3 (
    .clk(clk), .nRST(nRST), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
    .rsp_valid(c3_rsp), .rsp_rdata(c3_rdata),
    .cpld_SS(c3_ss), .cpld_SCK(c3_sck), .cpld_MOSI(c3_mosi), .cpld_MISO(c3_miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] frame;
    logic [7:0]  rdata;
    logic        is_read;
  } exp_t;
  exp_t sb[$];

  // CPLD slave model (mode 0): samples MOSI on SCK rise, shifts MISO on fall.
  logic [31:0] sl_rx = '0, sl_tx = '0, cap_frame = '0;
  int          sl_bits = 0;
  logic        prev_ss = 1'b1, prev_sck = 1'b0;
  logic        allow = 1'b1;
  logic [7:0]  slave_byte = 8'h00;

  always @(cpld_SS or cpld_SCK) begin
    if (cpld_SS !== prev_ss) begin
      if (!cpld_SS) begin
        sl_rx = '0; sl_bits = 0;
        sl_tx = {24'h0, slave_byte};
        cpld_MISO = sl_tx[31];
      end else begin
        cap_frame = sl_rx;
        if (sl_rx == 32'hFFFFFF00) allow = 1'b0;
        else if (sl_rx == 32'hFFFFFFFF) allow = 1'b1;
      end
    end else if ((cpld_SCK !== prev_sck) && !cpld_SS) begin
      if (cpld_SCK) begin
        sl_rx = {sl_rx[30:0], cpld_MOSI};
        sl_bits++;
      end else begin
        sl_tx = {sl_tx[30:0], 1'b0};
        cpld_MISO = sl_tx[31];
      end
    end
    prev_ss  = cpld_SS;
    prev_sck = cpld_SCK;
  end

  // Scoreboard monitor, SS low length and inter-frame gap for the main DUT.
  int   low_cnt = 0, high_cnt = 0;
  logic had_frame = 1'b0, mon_prev_ss = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!nRST) begin
      had_frame = 1'b0; low_cnt = 0; high_cnt = 0; mon_prev_ss = 1'b1;
    end else begin
      if (cpld_SS) begin
        high_cnt++;
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid with frame %h, expected none", cap_frame);
          end else begin
            e = sb.pop_front();
            check("frame", cap_frame, e.frame);
            check("ss_low_len", low_cnt, 66);
            if (e.is_read) check("rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
          end
          had_frame = 1'b1;
          high_cnt  = 1;
        end
        low_cnt = 0;
      end else begin
        if (mon_prev_ss && had_frame) begin
          checks++;
          if (high_cnt < SS_GAP + 1) begin
            errors++;
            $display("FAIL ss_gap: got %0d high cycles, required >= %0d", high_cnt, SS_GAP + 1);
          end
        end
        low_cnt++;
      end
      mon_prev_ss = cpld_SS;
    end
  end

  // SCK_DIV=3 instance: capture frame and measure phases.
  logic [31:0] c3_cap = '0;
  always @(posedge c3_sck) if (!c3_ss) c3_cap = {c3_cap[30:0], c3_mosi};

  int c3_hi = 0, c3_lo = 0, c3_low_len = 0, c3_rsp_cnt = 0;
  bit c3_seen = 1'b0;
  always @(negedge clk) begin
    if (!c3_ss) begin
      c3_low_len++;
      if (c3_sck) begin
        if (c3_seen && c3_lo > 0) check("c3_lo_phase", c3_lo, 3);
        c3_lo = 0;
        c3_hi++;
      end else begin
        if (c3_hi > 0) begin
          check("c3_hi_phase", c3_hi, 3);
          c3_seen = 1'b1;
          c3_hi = 0;
        end
        c3_lo++;
      end
    end else begin
      if (c3_rsp) begin
        check("c3_frame", c3_cap, 32'h2468AA50);
        check("c3_ss_low_len", c3_low_len, 198);
        c3_rsp_cnt++;
      end
      c3_low_len = 0; c3_hi = 0; c3_lo = 0; c3_seen = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [18:0] addr, input logic [7:0] wdata,
                       input logic [31:0] exp_frame, input logic [7:0] exp_rdata, input logic push);
    bit ok = 1'b0;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      if (push) sb.push_back('{frame: exp_frame, rdata: exp_rdata, is_read: (op == 2'b01)});
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready low for 1000 cycles, required accept");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    nRST = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    c3_valid = 1'b0; c3_op = '0; c3_addr = '0; c3_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ss", cpld_SS, 1'b1);
    check("rst_sck", cpld_SCK, 1'b0);
    check("rst_mosi", cpld_MOSI, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_c3_ss", c3_ss, 1'b1);
    nRST = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // Write, read
    @(negedge clk);
    issue(2'b00, 19'h51234, 8'h89, 32'hA2468890, 8'h00, 1'b1);
    cmd_valid = 1'b0;
    drain();
    slave_byte = 8'h42;
    issue(2'b01, 19'h70F0F, 8'h00, 32'hE1E1F000, 8'h42, 1'b1);
    cmd_valid = 1'b0;
    drain();

    // Lock / unlock; address and data must not leak into the frame
    issue(2'b10, 19'h12345, 8'h77, 32'hFFFFFF00, 8'h00, 1'b1);
    cmd_valid = 1'b0;
    drain();
    check("allow_after_lock", allow, 1'b0);
    issue(2'b11, 19'h00001, 8'h01, 32'hFFFFFFFF, 8'h00, 1'b1);
    cmd_valid = 1'b0;
    drain();
    check("allow_after_unlock", allow, 1'b1);

    // Back-to-back with cmd_valid held high
    slave_byte = 8'hC3;
    issue(2'b00, 19'h05555, 8'hAA, 32'h0AAAAAA0, 8'h00, 1'b1);
    issue(2'b00, 19'h02AAA, 8'h55, 32'h05554550, 8'h00, 1'b1);
    issue(2'b00, 19'h05555, 8'h90, 32'h0AAAA900, 8'h00, 1'b1);
    issue(2'b01, 19'h00000, 8'h00, 32'h00001000, 8'hC3, 1'b1);
    issue(2'b01, 19'h00001, 8'h00, 32'h00003000, 8'hC3, 1'b1);
    issue(2'b00, 19'h05555, 8'hF0, 32'h0AAAAF00, 8'h00, 1'b1);
    cmd_valid = 1'b0;
    drain();

    // Reset in the middle of a write frame
    issue(2'b00, 19'h3C3C3, 8'h5A, 32'h0, 8'h00, 1'b0);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (sl_bits >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_bit10", ok, 1'b1);
    nRST = 1'b0;
    #1;
    check("midrst_ss", cpld_SS, 1'b1);
    check("midrst_sck", cpld_SCK, 1'b0);
    check("midrst_mosi", cpld_MOSI, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rdata", rsp_rdata, 8'h00);
    check("midrst_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midrst", cmd_ready, 1'b1);
    check("no_resume_ss", cpld_SS, 1'b1);
    @(negedge clk);
    slave_byte = 8'h9D;
    issue(2'b01, 19'h00100, 8'h00, 32'h00201000, 8'h9D, 1'b1);
    cmd_valid = 1'b0;
    drain();

    // SCK_DIV=3 instance
    c3_op = 2'b00; c3_addr = 19'h12345; c3_wdata = 8'hA5; c3_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (c3_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("c3_accept", ok, 1'b1);
    #1 c3_valid = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (c3_rsp_cnt != 0) break;
    end
    repeat (5) @(negedge clk);
    check("c3_rsp_count", c3_rsp_cnt, 1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
